// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter                                                         |
// | Shares one synchronous-read memory between fetch and load/store ports    |
// | using 3-cycle IDLE/ACCESS/RESP transactions. Define ARB_RR_EN for        |
// | round-robin arbitration instead of data priority with fetch anti-starve. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_nextState;
    logic              r_grantFetch;
    logic              w_anyReq;
    logic              w_fetchWins;
    logic              w_grant;
    logic              w_resp;
    logic              r_mEn;
    logic              r_mWe;
    logic [ADDR_W-1:0] r_mAddr;
    logic [DATA_W-1:0] r_mWdata;
    logic [DATA_W-1:0] r_iRdata;
    logic [DATA_W-1:0] r_dRdata;

    assign w_anyReq = i_req | d_req;
    assign w_grant  = (r_state == c_IDLE) & w_anyReq;

`ifdef ARB_RR_EN
    logic r_lastFetch;

    // On a tie the port that did not win last time gets the memory.
    assign w_fetchWins = i_req & (~d_req | ~r_lastFetch);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastFetch <= 1'b1;
        end else if (w_grant) begin
            r_lastFetch <= w_fetchWins;
        end
    end
`else
    localparam logic [3:0] c_MAX_STARVE = 4'(MAX_STARVE);

    logic [3:0] r_starveCnt;

    assign w_fetchWins = i_req & (~d_req | (r_starveCnt == c_MAX_STARVE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starveCnt <= 4'd0;
        end else if (w_grant) begin
            if (w_fetchWins) begin
                r_starveCnt <= 4'd0;
            end else if (i_req && (r_starveCnt != c_MAX_STARVE)) begin
                r_starveCnt <= r_starveCnt + 4'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:   if (w_anyReq) w_nextState = c_ACCESS;
            c_ACCESS: w_nextState = c_RESP;
            c_RESP:   w_nextState = c_IDLE;
            default:  w_nextState = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mEn        <= 1'b0;
            r_mWe        <= 1'b0;
            r_mAddr      <= '0;
            r_mWdata     <= '0;
            r_grantFetch <= 1'b0;
            r_iRdata     <= '0;
            r_dRdata     <= '0;
        end else begin
            r_mEn <= 1'b0;
            r_mWe <= 1'b0;
            if (w_grant) begin
                r_mEn        <= 1'b1;
                r_mWe        <= ~w_fetchWins & d_we;
                r_mAddr      <= w_fetchWins ? i_addr : d_addr;
                r_mWdata     <= w_fetchWins ? '0 : d_wdata;
                r_grantFetch <= w_fetchWins;
            end
            // Capture the returned word so the port keeps it after its ack.
            if (r_state == c_RESP) begin
                if (r_grantFetch) begin
                    r_iRdata <= m_rdata;
                end else begin
                    r_dRdata <= m_rdata;
                end
            end
        end
    end

    assign w_resp  = (r_state == c_RESP);
    assign i_ack   = w_resp & r_grantFetch;
    assign d_ack   = w_resp & ~r_grantFetch;
    assign i_rdata = i_ack ? m_rdata : r_iRdata;
    assign d_rdata = d_ack ? m_rdata : r_dRdata;
    assign m_en    = r_mEn;
    assign m_we    = r_mWe;
    assign m_addr  = r_mAddr;
    assign m_wdata = r_mWdata;
    assign busy    = (r_state == c_ACCESS) | w_resp;

endmodule
`default_nettype wire
